// File: rtl/seg7_clock_divider.sv
// Free-running divider that makes the 7-segment scan clock CLK_OUT (50 % duty)
// plus one-cycle rise/fall strobes, all registered on CLK.
module seg7_clock_divider #(
   parameter int unsigned HALF_PERIOD = 50000,
   parameter int unsigned CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
   input  logic CLK,
   input  logic IN_CLR,
   output logic CLK_OUT,
   output logic RISE_TICK,
   output logic FALL_TICK
);

   if (HALF_PERIOD == 0 || HALF_PERIOD > (1 << 24)) begin : g_bad_half_period
      $error("seg7_clock_divider: HALF_PERIOD must be in 1..2^24");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_out_q, clk_out_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             at_last;

   // The counter resets explicitly at LAST so it never wraps through 2^CNT_W.
   always_comb begin
      at_last   = (cnt_q == LAST);
      cnt_d     = cnt_q + CNT_W'(1);
      clk_out_d = clk_out_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      if (at_last) begin
         cnt_d     = '0;
         clk_out_d = ~clk_out_q;
         rise_d    = ~clk_out_q;
         fall_d    = clk_out_q;
      end
   end

   always_ff @(posedge CLK or negedge IN_CLR) begin
      if (!IN_CLR) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign CLK_OUT   = clk_out_q;
   assign RISE_TICK = rise_q;
   assign FALL_TICK = fall_q;

endmodule

// File: tb/tb_seg7_clock_divider.sv
// Directed bench for seg7_clock_divider: HALF_PERIOD = 4, 1 and the 50000 default.
module tb_seg7_clock_divider;
  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic out_a, rise_a, fall_a;
  logic out_b, rise_b, fall_b;
  logic out_c, rise_c, fall_c;
  int n_cmp = 0;
  int n_err = 0;
  logic big_done = 1'b0;

  always #5 clk = ~clk;

  seg7_clock_divider #(.HALF_PERIOD(4)) dut_a (
    .CLK(clk), .IN_CLR(rst_a), .CLK_OUT(out_a), .RISE_TICK(rise_a), .FALL_TICK(fall_a));
  seg7_clock_divider #(.HALF_PERIOD(1)) dut_b (
    .CLK(clk), .IN_CLR(rst_b), .CLK_OUT(out_b), .RISE_TICK(rise_b), .FALL_TICK(fall_b));
  seg7_clock_divider dut_c (
    .CLK(clk), .IN_CLR(rst_c), .CLK_OUT(out_c), .RISE_TICK(rise_c), .FALL_TICK(fall_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected waveform k posedges after reset release, for half period h.
  function automatic logic exp_out(input int k, input int h);
    return ((k / h) % 2) == 1;
  endfunction
  function automatic logic exp_rise(input int k, input int h);
    return (k > 0) && (k % h == 0) && exp_out(k, h);
  endfunction
  function automatic logic exp_fall(input int k, input int h);
    return (k > 0) && (k % h == 0) && !exp_out(k, h);
  endfunction

  task automatic check_a(input int k);
    check_eq($sformatf("h4_out_k%0d", k), 32'(out_a), 32'(exp_out(k, 4)));
    check_eq($sformatf("h4_rise_k%0d", k), 32'(rise_a), 32'(exp_rise(k, 4)));
    check_eq($sformatf("h4_fall_k%0d", k), 32'(fall_a), 32'(exp_fall(k, 4)));
    check_eq($sformatf("h4_both_k%0d", k), 32'(rise_a & fall_a), 32'd0);
  endtask

  // Default-parameter smoke test runs alongside the short tests.
  initial begin
    repeat (2) @(negedge clk);
    rst_c = 1'b1;
    repeat (49999) @(posedge clk);
    #1;
    check_eq("h50000_low_before_edge", 32'(out_c), 32'd0);
    check_eq("h50000_no_rise_before_edge", 32'(rise_c), 32'd0);
    @(posedge clk); #1;
    check_eq("h50000_rise_at_50000", 32'(out_c), 32'd1);
    check_eq("h50000_rise_tick", 32'(rise_c), 32'd1);
    @(posedge clk); #1;
    check_eq("h50000_rise_tick_one_cycle", 32'(rise_c), 32'd0);
    check_eq("h50000_still_high", 32'(out_c), 32'd1);
    big_done = 1'b1;
  end

  initial begin
    // Reset hold.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("rst_out", 32'(out_a), 32'd0);
      check_eq("rst_rise", 32'(rise_a), 32'd0);
      check_eq("rst_fall", 32'(fall_a), 32'd0);
      check_eq("rst_cnt", 32'(dut_a.cnt_q), 32'd0);
    end

    // Five full periods at HALF_PERIOD = 4.
    rst_a = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      check_a(k);
    end

    // Async reset while CLK_OUT is high (k = 45).
    check_eq("pre_async_high", 32'(out_a), 32'd1);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check_eq("async_out_low", 32'(out_a), 32'd0);
    check_eq("async_no_fall", 32'(fall_a), 32'd0);
    check_eq("async_cnt_zero", 32'(dut_a.cnt_q), 32'd0);
    @(posedge clk); #1;
    check_eq("async_hold_out", 32'(out_a), 32'd0);
    check_eq("async_hold_fall", 32'(fall_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check_a(k);
    end

    // Divide-by-2.
    @(negedge clk);
    rst_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("h1_out_k%0d", k), 32'(out_b), 32'(k % 2));
      check_eq($sformatf("h1_rise_k%0d", k), 32'(rise_b), 32'(k % 2));
      check_eq($sformatf("h1_fall_k%0d", k), 32'(fall_b), 32'((k + 1) % 2));
    end

    // Bounded wait for the default-parameter test.
    for (int i = 0; i < 60000 && !big_done; i++) @(posedge clk);
    check_eq("h50000_finished", 32'(big_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
